// File: rtl/apb_initiator.sv
// Single-outstanding APB master: turns a valid/ready request into one APB
// transfer and returns the result on a valid/ready response channel.
module apb_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [STRB_WIDTH-1:0] req_strb_i,
  input  logic [2:0]            req_prot_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,

  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [2:0]            pprot_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  output logic [STRB_WIDTH-1:0] pstrb_o,
  input  logic                  pready_i,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pslverr_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   TO_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W:0]        cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          strb_d  = req_write_i ? req_strb_i : '0;
          prot_d  = req_prot_i;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (pready_i) begin
          rdata_d   = (!write_q && !pslverr_i) ? prdata_i : '0;
          err_d     = pslverr_i;
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          // The T-th wait cycle is the last one: ACCESS lasts exactly T cycles.
          if (TIMEOUT_CYCLES > 0 && cnt_inc == TO_LIMIT) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign psel_o        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign penable_o     = (state_q == S_ACCESS);
  assign rsp_valid_o   = (state_q == S_RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = timeout_q;
  assign paddr_o       = addr_q;
  assign pwrite_o      = write_q;
  assign pwdata_o      = wdata_q;
  assign pstrb_o       = strb_q;
  assign pprot_o       = prot_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator (TIMEOUT_CYCLES=4): vector table driving a small
// APB slave model, with expected responses queued and checked on rsp_valid.
module tb_apb_initiator;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_strb_i;
  logic [2:0]  req_prot_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_rdata_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic [2:0]  pprot_o;
  logic [3:0]  pstrb_o;
  logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;

  always #5 clk_i = ~clk_i;

  apb_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_write_i(req_write_i), .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .req_prot_i(req_prot_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;    // pready low cycles before completion; >= TO never completes
    logic        slverr;
    logic [31:0] prdata;
    int          bp;       // cycles of rsp_ready low, with req_valid held high
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_apb_fields(input vec_t v, input string tag);
    chk({tag, "_paddr"}, paddr_o, v.addr);
    chk({tag, "_pwrite"}, pwrite_o, v.write);
    chk({tag, "_pwdata"}, pwdata_o, v.wdata);
    chk({tag, "_pstrb"}, pstrb_o, v.write ? v.strb : 4'h0);
    chk({tag, "_pprot"}, pprot_o, v.prot);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
    chk({tag, "_rsp_err"}, rsp_err_o, 1'b0);
    chk({tag, "_rsp_timeout"}, rsp_timeout_o, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 32'h0);
    chk({tag, "_psel"}, psel_o, 1'b0);
    chk({tag, "_penable"}, penable_o, 1'b0);
    chk({tag, "_paddr"}, paddr_o, 32'h0);
    chk({tag, "_pwrite"}, pwrite_o, 1'b0);
    chk({tag, "_pwdata"}, pwdata_o, 32'h0);
    chk({tag, "_pstrb"}, pstrb_o, 4'h0);
    chk({tag, "_pprot"}, pprot_o, 3'h0);
  endtask

  task automatic drive_req(input vec_t v);
    req_valid_i = 1'b1;
    req_write_i = v.write;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    req_strb_i  = v.strb;
    req_prot_i  = v.prot;
  endtask

  task automatic do_xfer(input vec_t v);
    int   acc;
    int   exp_acc;
    rsp_t e;
    drive_req(v);
    chk("idle_req_ready", req_ready_o, 1'b1);
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_to});
    step();
    req_valid_i = 1'b0;
    chk("setup_psel", psel_o, 1'b1);
    chk("setup_penable", penable_o, 1'b0);
    chk("setup_rsp_valid", rsp_valid_o, 1'b0);
    check_apb_fields(v, "setup");
    // Slave noise during SETUP must not be sampled.
    pready_i  = 1'b1;
    pslverr_i = 1'b1;
    prdata_i  = 32'hBAD0_0000;
    step();
    acc = 0;
    while (psel_o && acc < 20) begin
      acc++;
      chk("access_penable", penable_o, 1'b1);
      chk("access_rsp_valid", rsp_valid_o, 1'b0);
      check_apb_fields(v, "access");
      pready_i  = (acc == v.waits + 1);
      prdata_i  = pready_i ? v.prdata : 32'hBAD0_0000 + acc;
      pslverr_i = pready_i ? v.slverr : 1'b1;
      step();
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    exp_acc = (v.waits >= TO) ? TO : v.waits + 1;
    chk("access_cycles", acc, exp_acc);
    chk("resp_valid", rsp_valid_o, 1'b1);
    chk("resp_psel", psel_o, 1'b0);
    chk("resp_penable", penable_o, 1'b0);
    chk("resp_req_ready", req_ready_o, 1'b0);
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
      e = '{32'h0, 1'b0, 1'b0};
    end else begin
      e = sb.pop_front();
    end
    chk("rsp_rdata", rsp_rdata_o, e.rdata);
    chk("rsp_err", rsp_err_o, e.err);
    chk("rsp_timeout", rsp_timeout_o, e.to);
    rsp_ready_i = 1'b0;
    for (int i = 0; i < v.bp; i++) begin
      req_valid_i = 1'b1;
      step();
      chk("bp_rsp_valid", rsp_valid_o, 1'b1);
      chk("bp_req_ready", req_ready_o, 1'b0);
      chk("bp_psel", psel_o, 1'b0);
      chk("bp_rdata", rsp_rdata_o, e.rdata);
      chk("bp_err", rsp_err_o, e.err);
      chk("bp_timeout", rsp_timeout_o, e.to);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b0;
    chk("done_rsp_valid", rsp_valid_o, 1'b0);
    chk("done_req_ready", req_ready_o, 1'b1);
    chk("done_psel", psel_o, 1'b0);
  endtask

  initial begin
    vec_t rv;
    //           wr    addr          wdata         strb  prot    waits slverr prdata        bp  exp_rdata     err   to
    vecs[0] = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010, 0,  1'b0, 32'h0,        0, 32'h0,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h2000_0010, 32'h5555_AAAA, 4'hF, 3'b001, 3,  1'b0, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h2000_0020, 32'h0,         4'h3, 3'b000, 1,  1'b1, 32'hFFFF_FFFF, 0, 32'h0,        1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h3000_0000, 32'h0,         4'h0, 3'b100, 99, 1'b0, 32'h0,        0, 32'h0,        1'b1, 1'b1};
    vecs[4] = '{1'b0, 32'h3000_0004, 32'h0,         4'h0, 3'b111, 3,  1'b0, 32'hA5A5_0001, 0, 32'hA5A5_0001, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h4000_0008, 32'h0,         4'hF, 3'b011, 0,  1'b0, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h4000_000C, 32'h0102_0304, 4'h5, 3'b110, 0,  1'b1, 32'h7777_7777, 0, 32'h0,        1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h5000_0000, 32'hFACE_0001, 4'h6, 3'b101, 2,  1'b0, 32'h9999_9999, 2, 32'h0,        1'b0, 1'b0};

    rst_i = 1'b1;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_strb_i = '0; req_prot_i = '0; rsp_ready_i = 1'b0;
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    check_reset_values("reset");

    for (int i = 0; i < 8; i++) do_xfer(vecs[i]);

    // Reset while the slave is stalling in ACCESS: transfer is dropped.
    rv = '{1'b1, 32'h6000_0000, 32'h1111_2222, 4'hF, 3'b001, 99, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0};
    drive_req(rv);
    step();
    req_valid_i = 1'b0;
    step();
    chk("rst_pre_penable", penable_o, 1'b1);
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_reset_values("mid_rst");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_no_rsp", rsp_valid_o, 1'b0);
    end
    do_xfer(vecs[1]);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
